// File: rtl/regfile_sb.sv
// Register file with per-register pending (scoreboard) bits, two combinational
// read ports with writeback bypass, and a registered count of pending registers.

module regfile_sb_rdport #(
   parameter int W           = 32,
   parameter int REGADDR_LEN = 5,
   parameter int NREG        = 32,
   parameter int ZERO_REG    = 1
) (
   input  logic [NREG-1:0][W-1:0]    rf,
   input  logic [NREG-1:0]           pend,
   input  logic                      w,
   input  logic [REGADDR_LEN-1:0]    w_reg,
   input  logic [W-1:0]              w_data,
   input  logic [REGADDR_LEN-1:0]    r_reg,
   output logic [W-1:0]              r_data,
   output logic                      busy
);
   logic is_zero;
   logic wb_hit;

   always_comb begin
      is_zero = (ZERO_REG != 0) && (r_reg == '0);
      wb_hit  = w && (w_reg == r_reg);
      r_data  = rf[r_reg];
      busy    = pend[r_reg];
      // A same-cycle writeback both forwards its data and releases the reader.
      if (wb_hit) begin
         r_data = w_data;
         busy   = 1'b0;
      end
      if (is_zero) begin
         r_data = '0;
         busy   = 1'b0;
      end
   end
endmodule

module regfile_sb #(
   parameter int W           = 32,
   parameter int REGADDR_LEN = 5,
   parameter int ZERO_REG    = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   w,
   input  logic [REGADDR_LEN-1:0] W_Reg,
   input  logic [W-1:0]           W_Data,
   input  logic                   iss,
   input  logic [REGADDR_LEN-1:0] Iss_Reg,
   input  logic                   flush,
   input  logic [REGADDR_LEN-1:0] R_Reg1,
   input  logic [REGADDR_LEN-1:0] R_Reg2,
   output logic [W-1:0]           R_Data1,
   output logic [W-1:0]           R_Data2,
   output logic                   busy1,
   output logic                   busy2,
   output logic [REGADDR_LEN:0]   pend_cnt
);
   localparam int NREG   = 2 ** REGADDR_LEN;
   localparam int NPORTS = 2;

   logic [NREG-1:0][W-1:0]        rf_q, rf_d;
   logic [NREG-1:0]               pend_q, pend_d;
   logic [REGADDR_LEN:0]          pend_cnt_q, pend_cnt_d;
   logic                          wr_ok, iss_ok;

   logic [NPORTS-1:0][REGADDR_LEN-1:0] r_reg_a;
   logic [NPORTS-1:0][W-1:0]           r_data_a;
   logic [NPORTS-1:0]                  busy_a;

   always_comb begin
      wr_ok  = w && !((ZERO_REG != 0) && (W_Reg == '0));
      // Flush drops any issue arriving in the same cycle.
      iss_ok = iss && !flush && !((ZERO_REG != 0) && (Iss_Reg == '0));

      rf_d = rf_q;
      if (wr_ok) rf_d[W_Reg] = W_Data;

      pend_d = pend_q;
      if (flush) begin
         pend_d = '0;
      end else begin
         if (w)      pend_d[W_Reg]   = 1'b0;
         // Applied after the clear so a new producer wins over the writeback.
         if (iss_ok) pend_d[Iss_Reg] = 1'b1;
      end

      pend_cnt_d = '0;
      for (int i = 0; i < NREG; i++)
         pend_cnt_d = pend_cnt_d + (REGADDR_LEN+1)'(pend_d[i]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_q       <= '0;
         pend_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         rf_q       <= rf_d;
         pend_q     <= pend_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   assign r_reg_a[0] = R_Reg1;
   assign r_reg_a[1] = R_Reg2;

   for (genvar p = 0; p < NPORTS; p++) begin : g_rd
      regfile_sb_rdport #(
         .W(W), .REGADDR_LEN(REGADDR_LEN), .NREG(NREG), .ZERO_REG(ZERO_REG)
      ) u_rd (
         .rf     (rf_q),
         .pend   (pend_q),
         .w      (w),
         .w_reg  (W_Reg),
         .w_data (W_Data),
         .r_reg  (r_reg_a[p]),
         .r_data (r_data_a[p]),
         .busy   (busy_a[p])
      );
   end

   assign R_Data1  = r_data_a[0];
   assign R_Data2  = r_data_a[1];
   assign busy1    = busy_a[0];
   assign busy2    = busy_a[1];
   assign pend_cnt = pend_cnt_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expected outputs, a
// negedge monitor pops and compares them against the DUT.

module tb_regfile_sb;
   logic        clk, rst;
   logic        w, iss, flush;
   logic [4:0]  W_Reg, Iss_Reg, R_Reg1, R_Reg2;
   logic [31:0] W_Data, R_Data1, R_Data2;
   logic        busy1, busy2;
   logic [5:0]  pend_cnt;

   int ntests = 0;
   int nfail  = 0;

   typedef struct {
      string       name;
      int          kind;   // 0 R_Data1, 1 R_Data2, 2 busy1, 3 busy2, 4 pend_cnt
      logic [31:0] val;
   } exp_t;
   exp_t q[$];

   regfile_sb #(.W(32), .REGADDR_LEN(5), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst), .w(w), .W_Reg(W_Reg), .W_Data(W_Data),
      .iss(iss), .Iss_Reg(Iss_Reg), .flush(flush),
      .R_Reg1(R_Reg1), .R_Reg2(R_Reg2), .R_Data1(R_Data1), .R_Data2(R_Data2),
      .busy1(busy1), .busy2(busy2), .pend_cnt(pend_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic exp_push(input string n, input int k, input logic [31:0] v);
      exp_t e;
      e.name = n; e.kind = k; e.val = v;
      q.push_back(e);
   endtask

   // Drive one cycle's inputs just after the rising edge.
   task automatic cyc(input logic wi, input logic [4:0] wr, input logic [31:0] wd,
                      input logic ii, input logic [4:0] ir, input logic fl,
                      input logic [4:0] r1, input logic [4:0] r2);
      @(posedge clk); #1;
      w = wi; W_Reg = wr; W_Data = wd; iss = ii; Iss_Reg = ir; flush = fl;
      R_Reg1 = r1; R_Reg2 = r2;
   endtask

   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         logic [31:0] act;
         e = q.pop_front();
         case (e.kind)
            0: act = R_Data1;
            1: act = R_Data2;
            2: act = {31'd0, busy1};
            3: act = {31'd0, busy2};
            default: act = {26'd0, pend_cnt};
         endcase
         ntests++;
         if (act !== e.val) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
         end
      end
   end

   initial begin
      rst = 1'b0; w = 0; W_Reg = 0; W_Data = 0; iss = 0; Iss_Reg = 0; flush = 0;
      R_Reg1 = 5; R_Reg2 = 0;
      #1;
      exp_push("rst_rdata1", 0, 32'h0);
      exp_push("rst_busy1", 2, 32'h0);
      exp_push("rst_cnt", 4, 32'h0);
      #6 rst = 1'b1;

      // bypass then stored read
      cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 6);
      exp_push("bypass_r1", 0, 32'hDEADBEEF);
      exp_push("unwritten_r2", 1, 32'h0);
      cyc(0, 0, 0, 0, 0, 0, 5, 6);
      exp_push("stored_r1", 0, 32'hDEADBEEF);

      // zero register
      cyc(1, 0, 32'h1234, 0, 0, 0, 5, 0);
      exp_push("zero_bypass_r2", 1, 32'h0);
      exp_push("zero_busy2", 3, 32'h0);
      cyc(0, 0, 0, 1, 0, 0, 5, 0);
      exp_push("zero_stored_r2", 1, 32'h0);
      cyc(0, 0, 0, 1, 7, 0, 5, 0);
      exp_push("zero_iss_cnt", 4, 32'h0);

      // issue 7, release by writeback
      cyc(0, 0, 0, 0, 0, 0, 7, 0);
      exp_push("iss7_busy1", 2, 32'h1);
      exp_push("iss7_cnt", 4, 32'h1);
      cyc(1, 7, 32'h77, 0, 0, 0, 7, 0);
      exp_push("wb7_busy1_comb", 2, 32'h0);
      exp_push("wb7_bypass", 0, 32'h77);
      exp_push("wb7_cnt_pre", 4, 32'h1);
      cyc(0, 0, 0, 0, 0, 0, 7, 0);
      exp_push("wb7_cnt_post", 4, 32'h0);
      exp_push("wb7_busy1_post", 2, 32'h0);
      exp_push("wb7_data", 0, 32'h77);

      // issue and writeback to same pending register: issue wins
      cyc(0, 0, 0, 1, 9, 0, 9, 0);
      cyc(1, 9, 32'h99, 1, 9, 0, 9, 0);
      exp_push("same9_busy_comb", 2, 32'h0);
      exp_push("same9_bypass", 0, 32'h99);
      cyc(0, 0, 0, 0, 0, 0, 9, 0);
      exp_push("same9_data", 0, 32'h99);
      exp_push("same9_busy", 2, 32'h1);
      exp_push("same9_cnt", 4, 32'h1);
      cyc(1, 9, 32'h99, 0, 0, 0, 9, 0);

      // flush with simultaneous issue and write
      cyc(0, 0, 0, 1, 1, 0, 0, 0);
      exp_push("pre_flush_cnt0", 4, 32'h0);
      cyc(0, 0, 0, 1, 2, 0, 0, 0);
      cyc(0, 0, 0, 1, 3, 0, 0, 0);
      cyc(1, 10, 32'hABC, 1, 4, 1, 1, 2);
      exp_push("pre_flush_cnt3", 4, 32'h3);
      exp_push("pre_flush_busy1", 2, 32'h1);
      exp_push("pre_flush_busy2", 3, 32'h1);
      cyc(0, 0, 0, 0, 0, 0, 4, 3);
      exp_push("flush_cnt", 4, 32'h0);
      exp_push("flush_busy1", 2, 32'h0);
      exp_push("flush_busy2", 3, 32'h0);
      cyc(0, 0, 0, 0, 0, 0, 10, 1);
      exp_push("flush_wdata", 0, 32'hABC);
      exp_push("flush_busy2_r1", 3, 32'h0);

      // asynchronous reset between edges
      cyc(1, 3, 32'hA5A5A5A5, 1, 3, 0, 3, 0);
      cyc(0, 0, 0, 0, 0, 0, 3, 0);
      exp_push("r3_data", 0, 32'hA5A5A5A5);
      exp_push("r3_busy", 2, 32'h1);
      exp_push("r3_cnt", 4, 32'h1);
      cyc(0, 0, 0, 0, 0, 0, 3, 0);
      #2 rst = 1'b0;
      exp_push("arst_data", 0, 32'h0);
      exp_push("arst_busy", 2, 32'h0);
      exp_push("arst_cnt", 4, 32'h0);
      #4 rst = 1'b1;

      // first edge after reset behaves normally
      cyc(1, 3, 32'h33, 1, 3, 0, 3, 0);
      cyc(0, 0, 0, 0, 0, 0, 3, 0);
      exp_push("post_rst_data", 0, 32'h33);
      exp_push("post_rst_busy", 2, 32'h1);
      exp_push("post_rst_cnt", 4, 32'h1);

      for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         nfail++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter W, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter REGADDR_LEN, default 5, meaning register address width; register count NREG = 2**REGADDR_LEN.
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning that when it is 1, register 0 reads as zero and is never written or marked pending.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-006 SHALL have port w, input, 1, meaning writeback enable.
REQ-007 SHALL have port W_Reg, input, REGADDR_LEN, meaning writeback destination.
REQ-008 SHALL have port W_Data, input, W, meaning writeback data.
REQ-009 SHALL have port iss, input, 1, meaning issue strobe that marks Iss_Reg pending.
REQ-010 SHALL have port Iss_Reg, input, REGADDR_LEN, meaning destination of the issuing instruction.
REQ-011 SHALL have port flush, input, 1, meaning clear all pending marks.
REQ-012 SHALL have ports R_Reg1 and R_Reg2, input, REGADDR_LEN each, meaning read addresses.
REQ-013 SHALL have ports R_Data1 and R_Data2, output, W each, meaning read data.
REQ-014 SHALL have ports busy1 and busy2, output, 1 each, meaning the read register is pending, not yet written back.
REQ-015 SHALL have port pend_cnt, output, REGADDR_LEN+1, meaning the number of registers currently pending.

Function
REQ-016 SHALL store NREG words of W bits plus one pending bit per register.
REQ-017 SHALL write W_Data into W_Reg at the rising clk edge when w=1, except register 0 when ZERO_REG=1.
REQ-018 SHALL produce R_DataN combinationally from R_RegN, with no clock latency.
REQ-019 SHALL bypass: when w=1 and W_Reg==R_RegN (and not the zero register), R_DataN SHALL equal W_Data in the same cycle.
REQ-020 SHALL force R_DataN=0 and busyN=0 when R_RegN==0 and ZERO_REG=1.
REQ-021 SHALL set the pending bit of Iss_Reg at the clk edge when iss=1 (ignored for the zero register).
REQ-022 SHALL clear the pending bit of W_Reg at the clk edge when w=1.
REQ-023 SHALL leave the bit set when iss and w target the same register in one cycle (issue wins: a new producer is in flight).
REQ-024 SHALL accept writeback to a non-pending register: data updates, pending stays 0.
REQ-025 SHALL make busyN = pending[R_RegN] AND NOT (w AND W_Reg==R_RegN), so that a same-cycle writeback releases the reader.
REQ-026 SHALL, when flush=1, clear all pending bits at the clk edge; iss in the same cycle SHALL be dropped; w SHALL still write data.
REQ-027 SHALL update pend_cnt registered alongside the pending bits, always equal to the popcount of the pending bits; it SHALL never exceed NREG-ZERO_REG.
REQ-028 SHALL change neither data nor pending bits when w=0, iss=0, and flush=0.

Reset
REQ-029 SHALL, while rst=0, asynchronously clear all registers to 0, all pending bits to 0, and pend_cnt to 0; consequently R_Data1=R_Data2=0 (absent bypass) and busy1=busy2=0.
REQ-030 SHALL abort all in-flight pending marks when reset is asserted mid-operation; the first edge after rst deasserts SHALL behave as normal operation.

Verification
REQ-031 SHALL pass this scenario: reset, then w=1, W_Reg=5, W_Data=0xDEADBEEF, R_Reg1=5 -> R_Data1=0xDEADBEEF in the same cycle (bypass) and in the next cycle with w=0.
REQ-032 SHALL pass this scenario: w=1, W_Reg=0, W_Data=0x1234, then R_Reg2=0 -> R_Data2=0, busy2=0; iss with Iss_Reg=0 -> pend_cnt stays 0.
REQ-033 SHALL pass this scenario: iss with Iss_Reg=7, then R_Reg1=7 -> busy1=1 and pend_cnt=1; next cycle w=1, W_Reg=7 -> busy1=0 combinationally; after the edge pend_cnt=0.
REQ-034 SHALL pass this scenario: pending bit of register 9 set, then iss=1 with Iss_Reg=9 and w=1 with W_Reg=9 in one cycle -> register 9 holds W_Data, busy remains 1, pend_cnt unchanged.
REQ-035 SHALL pass this scenario: issue registers 1, 2, and 3 (pend_cnt=3), then flush=1 with iss, Iss_Reg=4 -> pend_cnt=0 and all busy outputs 0.
REQ-036 SHALL pass this scenario: write register 3=0xA5A5A5A5 and issue register 3, then assert rst=0 between edges -> R_Data for register 3 reads 0 and busy is 0 immediately, before the next clk edge.
